// File: rtl/ysyx_22041412_icache_pkg.sv
// Shared definitions for the instruction cache.
//   - ic_state_e : controller state encoding
//   - LINE_BITS  : cache line width in bits
//   - OFFSET_BITS: byte-offset bits within a line (ignored on lookup)
package ysyx_22041412_icache_pkg;

   localparam int LINE_BITS   = 128;
   localparam int OFFSET_BITS = 4;

   typedef enum logic [2:0] {
      IC_IDLE        = 3'd0,
      IC_LOOKUP      = 3'd1,
      IC_REFILL_REQ  = 3'd2,
      IC_REFILL_DATA = 3'd3,
      IC_RESP        = 3'd4
   } ic_state_e;

endpackage

// File: rtl/ysyx_22041412_icache_array.sv
// Tag / valid / data storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears valid bits)
//   flush           : flash-invalidate every line this cycle
//   rd_index        : lookup index; rd_valid/rd_tag/rd_data are combinational
//   wr_en/wr_index  : single write port, installs tag+data and sets valid
//   wr_tag/wr_data  : line being installed
module ysyx_22041412_icache_array
   import ysyx_22041412_icache_pkg::*;
#(
   parameter int SETS  = 64,
   parameter int IDX_W = 6,
   parameter int TAG_W = 22
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [IDX_W-1:0]     rd_index,
   output logic                 rd_valid,
   output logic [TAG_W-1:0]     rd_tag,
   output logic [LINE_BITS-1:0] rd_data,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_index,
   input  logic [TAG_W-1:0]     wr_tag,
   input  logic [LINE_BITS-1:0] wr_data
);

   logic [LINE_BITS-1:0] data_mem [SETS];
   logic [TAG_W-1:0]     tag_mem  [SETS];
   logic [SETS-1:0]      valid_reg;
   logic [SETS-1:0]      valid_next;

   // Tag and data carry no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[wr_index] <= wr_data;
         tag_mem[wr_index]  <= wr_tag;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < SETS; gi++) begin : g_valid
         assign valid_next[gi] = ~flush &
                                 (valid_reg[gi] | (wr_en && (wr_index == IDX_W'(gi))));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= '0;
      end else begin
         valid_reg <= valid_next;
      end
   end

   assign rd_valid = valid_reg[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/ysyx_22041412_icache.sv
// Direct-mapped, read-only instruction cache (responder to the IFU fetch handshake).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   valid_i, addr_i          : IFU line request (addr_i[3:0] ignored)
//   ready_o, rdata_o         : one-cycle response pulse, line held until next pulse
//   clean_i, clear_o         : IFU abort request / abort-complete indication
//   fence_i                  : invalidate all lines
//   mem_valid_o, mem_addr_o,
//   mem_ready_i              : refill request handshake (line-aligned address)
//   mem_rvalid_i, mem_rdata_i,
//   mem_rlast_i              : refill beats, lowest beat first
module ysyx_22041412_icache
   import ysyx_22041412_icache_pkg::*;
#(
   parameter int SETS   = 64,
   parameter int MEM_DW = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_i,
   input  logic [31:0]          addr_i,
   output logic                 ready_o,
   output logic [LINE_BITS-1:0] rdata_o,
   input  logic                 clean_i,
   output logic                 clear_o,
   input  logic                 fence_i,
   output logic                 mem_valid_o,
   output logic [31:0]          mem_addr_o,
   input  logic                 mem_ready_i,
   input  logic                 mem_rvalid_i,
   input  logic [MEM_DW-1:0]    mem_rdata_i,
   input  logic                 mem_rlast_i
);

   localparam int IDX_W   = $clog2(SETS);
   localparam int LADDR_W = 32 - OFFSET_BITS;
   localparam int TAG_W   = LADDR_W - IDX_W;
   localparam int BEATS   = LINE_BITS / MEM_DW;
   localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

   ic_state_e            state_reg, state_next;
   logic [LADDR_W-1:0]   req_addr_reg, req_addr_next;
   logic                 aborted_reg, aborted_next;
   logic                 fence_pend_reg, fence_pend_next;
   logic [CNT_W-1:0]     beat_cnt_reg, beat_cnt_next;
   logic [LINE_BITS-1:0] line_buf_reg, line_buf_next;
   logic                 ready_reg, ready_next;
   logic [LINE_BITS-1:0] rdata_reg, rdata_next;
   logic                 mem_valid_reg, mem_valid_next;
   logic [31:0]          mem_addr_reg, mem_addr_next;

   logic                 rd_valid;
   logic [TAG_W-1:0]     rd_tag;
   logic [LINE_BITS-1:0] rd_data;
   logic                 wr_en;
   logic                 flush;
   logic                 hit;
   logic                 last_beat;
   logic                 abort_now;
   logic [LINE_BITS-1:0] beat_line;
   logic                 unused_offset;

   assign unused_offset = ^addr_i[OFFSET_BITS-1:0];

   ysyx_22041412_icache_array #(
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .rd_index (req_addr_reg[IDX_W-1:0]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_index (req_addr_reg[IDX_W-1:0]),
      .wr_tag   (req_addr_reg[LADDR_W-1:IDX_W]),
      .wr_data  (beat_line)
   );

   assign hit = rd_valid && (rd_tag == req_addr_reg[LADDR_W-1:IDX_W]);

   // Line buffer with the incoming beat merged into its slot; this is what gets
   // written to the array and returned when the final beat arrives.
   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_beat
         assign beat_line[gi*MEM_DW +: MEM_DW] =
            (beat_cnt_reg == CNT_W'(gi)) ? mem_rdata_i : line_buf_reg[gi*MEM_DW +: MEM_DW];
      end
   endgenerate

   // Either the memory flags the end, or the counter says the line is full.
   assign last_beat = mem_rlast_i || (beat_cnt_reg == CNT_W'(BEATS - 1));
   // An abort raised in the very cycle of a decision counts as well.
   assign abort_now = aborted_reg | clean_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IC_IDLE;
         req_addr_reg   <= '0;
         aborted_reg    <= 1'b0;
         fence_pend_reg <= 1'b0;
         beat_cnt_reg   <= '0;
         line_buf_reg   <= '0;
         ready_reg      <= 1'b0;
         rdata_reg      <= '0;
         mem_valid_reg  <= 1'b0;
         mem_addr_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         req_addr_reg   <= req_addr_next;
         aborted_reg    <= aborted_next;
         fence_pend_reg <= fence_pend_next;
         beat_cnt_reg   <= beat_cnt_next;
         line_buf_reg   <= line_buf_next;
         ready_reg      <= ready_next;
         rdata_reg      <= rdata_next;
         mem_valid_reg  <= mem_valid_next;
         mem_addr_reg   <= mem_addr_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      req_addr_next   = req_addr_reg;
      aborted_next    = aborted_reg | clean_i;
      fence_pend_next = fence_pend_reg;
      beat_cnt_next   = beat_cnt_reg;
      line_buf_next   = line_buf_reg;
      ready_next      = 1'b0;
      rdata_next      = rdata_reg;
      mem_valid_next  = mem_valid_reg;
      mem_addr_next   = mem_addr_reg;
      wr_en           = 1'b0;
      flush           = 1'b0;

      // A fence outside IDLE is remembered so a line installed by an in-flight
      // refill is still wiped before any later lookup.
      if (fence_i && (state_reg != IC_IDLE)) begin
         fence_pend_next = 1'b1;
      end

      case (state_reg)
         IC_IDLE: begin
            aborted_next = 1'b0;
            if (fence_pend_reg || fence_i) begin
               flush           = 1'b1;
               fence_pend_next = 1'b0;
            end else if (valid_i && !clean_i) begin
               req_addr_next = addr_i[31:OFFSET_BITS];
               state_next    = IC_LOOKUP;
            end
         end
         IC_LOOKUP: begin
            if (abort_now) begin
               state_next = IC_IDLE;
            end else if (hit) begin
               rdata_next = rd_data;
               ready_next = 1'b1;
               state_next = IC_RESP;
            end else begin
               mem_valid_next = 1'b1;
               mem_addr_next  = {req_addr_reg, {OFFSET_BITS{1'b0}}};
               state_next     = IC_REFILL_REQ;
            end
         end
         IC_REFILL_REQ: begin
            if (mem_ready_i) begin
               mem_valid_next = 1'b0;
               state_next     = IC_REFILL_DATA;
            end
         end
         IC_REFILL_DATA: begin
            // An abort here only suppresses the response; the refill is drained
            // and the line installed so the memory side never sees a cancel.
            if (mem_rvalid_i) begin
               line_buf_next = beat_line;
               if (last_beat) begin
                  beat_cnt_next = '0;
                  wr_en         = 1'b1;
                  if (abort_now) begin
                     state_next = IC_IDLE;
                  end else begin
                     rdata_next = beat_line;
                     ready_next = 1'b1;
                     state_next = IC_RESP;
                  end
               end else begin
                  beat_cnt_next = beat_cnt_reg + CNT_W'(1);
               end
            end
         end
         IC_RESP: begin
            state_next = IC_IDLE;
         end
         default: begin
            state_next = IC_IDLE;
         end
      endcase
   end

   assign ready_o     = ready_reg;
   assign rdata_o     = rdata_reg;
   assign mem_valid_o = mem_valid_reg;
   assign mem_addr_o  = mem_addr_reg;
   assign clear_o     = (state_reg == IC_IDLE) && !mem_valid_reg;

endmodule

// File: tb/tb_ysyx_22041412_icache.sv
// Directed testbench for ysyx_22041412_icache with a response scoreboard.
module tb_ysyx_22041412_icache;

   logic         clk;
   logic         rst;
   logic         valid_i;
   logic [31:0]  addr_i;
   logic         ready_o;
   logic [127:0] rdata_o;
   logic         clean_i;
   logic         clear_o;
   logic         fence_i;
   logic         mem_valid_o;
   logic [31:0]  mem_addr_o;
   logic         mem_ready_i;
   logic         mem_rvalid_i;
   logic [63:0]  mem_rdata_i;
   logic         mem_rlast_i;

   int n_cmp = 0;
   int n_bad = 0;
   int ready_cnt = 0;
   logic [127:0] sb [$];

   ysyx_22041412_icache #(.SETS(64), .MEM_DW(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .addr_i       (addr_i),
      .ready_o      (ready_o),
      .rdata_o      (rdata_o),
      .clean_i      (clean_i),
      .clear_o      (clear_o),
      .fence_i      (fence_i),
      .mem_valid_o  (mem_valid_o),
      .mem_addr_o   (mem_addr_o),
      .mem_ready_i  (mem_ready_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .mem_rlast_i  (mem_rlast_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts response pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (ready_o === 1'b1) ready_cnt++;
   end

   function automatic logic [127:0] line_of(input logic [31:0] a);
      logic [31:0] b;
      b = a & ~32'hF;
      if (b == 32'h8000_0000) return 128'h00000117_00000297_00000013_00000093;
      return {b, ~b, b ^ 32'h5a5a_5a5a, b + 32'd1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_resp(input logic [31:0] a);
      logic [127:0] e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL sb_underflow: observed empty queue expected entry for %h", a);
      end else begin
         e = sb.pop_front();
         chk($sformatf("rdata_%h", a), rdata_o, e);
      end
   endtask

   // One IFU transaction plus the matching memory behaviour.
   task automatic fetch(input logic [31:0] a, input bit miss, input bit do_clean,
                        input bit do_fence, input bit do_rst);
      logic [127:0] l;
      bit want;
      int rc0;
      l    = line_of(a);
      want = !(do_clean || do_rst);
      if (want) sb.push_back(l);
      rc0 = ready_cnt;
      valid_i = 1'b1;
      addr_i  = a;
      tick();
      tick();
      if (!miss) begin
         chk($sformatf("hit_ready_%h", a), ready_o, 1'b1);
         chk("hit_no_refill", mem_valid_o, 1'b0);
         check_resp(a);
      end else begin
         chk($sformatf("miss_req_%h", a), mem_valid_o, 1'b1);
         chk("miss_addr", mem_addr_o, a & ~32'hF);
         chk("miss_busy", clear_o, 1'b0);
         tick();
         chk("req_hold", mem_valid_o, 1'b1);
         mem_ready_i = 1'b1;
         tick();
         mem_ready_i = 1'b0;
         chk("req_drop", mem_valid_o, 1'b0);
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = l[63:0];
         fence_i      = do_fence;
         tick();
         mem_rvalid_i = 1'b0;
         fence_i      = 1'b0;
         if (do_rst) begin
            valid_i = 1'b0;
            rst     = 1'b1;
            tick();
            rst = 1'b0;
            chk("rst_ready", ready_o, 1'b0);
            chk("rst_rdata", rdata_o, '0);
            chk("rst_mem_valid", mem_valid_o, 1'b0);
            chk("rst_mem_addr", mem_addr_o, '0);
            chk("rst_clear", clear_o, 1'b1);
            tick();
            tick();
            chk("rst_ready_count", ready_cnt - rc0, 0);
            return;
         end
         clean_i = do_clean;
         if (do_clean) valid_i = 1'b0;
         tick();
         clean_i = 1'b0;
         chk("gap_busy", clear_o, 1'b0);
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = l[127:64];
         mem_rlast_i  = 1'b1;
         tick();
         mem_rvalid_i = 1'b0;
         mem_rlast_i  = 1'b0;
         if (do_clean) begin
            chk("abort_no_ready", ready_o, 1'b0);
            chk("abort_clear", clear_o, 1'b1);
         end else begin
            chk($sformatf("miss_ready_%h", a), ready_o, 1'b1);
            check_resp(a);
         end
      end
      valid_i = 1'b0;
      tick();
      chk("ready_pulse_end", ready_o, 1'b0);
      chk("idle_clear", clear_o, 1'b1);
      tick();
      chk($sformatf("ready_count_%h", a), ready_cnt - rc0, want ? 1 : 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      valid_i      = 1'b0;
      addr_i       = '0;
      clean_i      = 1'b0;
      fence_i      = 1'b0;
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_rlast_i  = 1'b0;
      tick();
      tick();
      chk("reset_ready", ready_o, 1'b0);
      chk("reset_rdata", rdata_o, '0);
      chk("reset_mem_valid", mem_valid_o, 1'b0);
      chk("reset_mem_addr", mem_addr_o, '0);
      chk("reset_clear", clear_o, 1'b1);
      rst = 1'b0;
      tick();

      // Cold miss, then hit on the same line with a different offset.
      fetch(32'h8000_0000, 1, 0, 0, 0);
      $display("txn cold miss 80000000 done");
      fetch(32'h8000_0008, 0, 0, 0, 0);
      $display("txn hit 80000008 done");

      // Conflict on index 0, then the original line misses again.
      fetch(32'h8000_0400, 1, 0, 0, 0);
      $display("txn conflict miss 80000400 done");
      fetch(32'h8000_0000, 1, 0, 0, 0);
      $display("txn re-miss 80000000 done");

      // Abort mid-refill: no response, but the line is installed.
      fetch(32'h8000_0020, 1, 1, 0, 0);
      $display("txn aborted refill 80000020 done");
      fetch(32'h8000_0024, 0, 0, 0, 0);
      $display("txn hit after abort 80000024 done");

      // clean_i and valid_i together in IDLE: nothing latched.
      valid_i = 1'b1;
      addr_i  = 32'h8000_0050;
      clean_i = 1'b1;
      tick();
      valid_i = 1'b0;
      clean_i = 1'b0;
      tick();
      chk("clean_wins_no_refill", mem_valid_o, 1'b0);
      chk("clean_wins_clear", clear_o, 1'b1);
      chk("clean_wins_no_ready", ready_o, 1'b0);
      $display("txn clean+valid idle done");

      // Fence during refill: line served, then invalidated.
      fetch(32'h8000_0010, 1, 0, 1, 0);
      $display("txn fenced refill 80000010 done");
      fetch(32'h8000_0010, 1, 0, 0, 0);
      $display("txn post-fence miss 80000010 done");
      fetch(32'h8000_001C, 0, 0, 0, 0);
      $display("txn hit 8000001c done");

      // Reset mid-refill: nothing installed.
      fetch(32'h8000_0030, 1, 0, 0, 1);
      $display("txn reset mid-refill 80000030 done");
      fetch(32'h8000_0030, 1, 0, 0, 0);
      $display("txn post-reset miss 80000030 done");

      chk("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
